fd_pipe_reg: RTL and testbench
==============================

Name: fd_pipe_reg

Overview:
- Fetch/Decode boundary register of the 5-stage MIPS pipeline.
- Captures the fetched instruction, its PC, its delay-slot flag and any fetch-side exception.
- Presents the held instruction's fields to D-stage consumers. The immediate extender takes `D_imm16`; the controller takes opcode/funct; the GRF takes rs/rt.
- Implements stall hold and exception/interrupt clear.

Parameters:
- TEXT_LO, 32'h0000_3000, lowest legal instruction address (inclusive).
- TEXT_HI, 32'h0000_6FFC, highest legal instruction address (inclusive).
- EXC_PC, 32'h0000_4180, handler entry PC loaded into D on exception clear.
- EXC_ADEL, 5'd4, exception code for fetch address error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  1 = load from F; 0 = hold (stall from hazard unit).
- req  in  1  exception/interrupt taken this cycle (from CP0); clears the stage.
- F_pc  in  32  PC of instruction in F.
- F_instr  in  32  instruction word from IM.
- F_bd  in  1  F instruction is in a branch/jump delay slot.
- D_pc  out  32  registered PC.
- D_instr  out  32  registered instruction (0 = nop).
- D_exccode  out  5  registered fetch exception code (0 = none).
- D_bd  out  1  registered delay-slot flag.
- D_valid  out  1  D holds a real fetched instruction (not a bubble).
- D_opcode  out  6  D_instr[31:26].
- D_rs  out  5  D_instr[25:21].
- D_rt  out  5  D_instr[20:16].
- D_rd  out  5  D_instr[15:11].
- D_shamt  out  5  D_instr[10:6].
- D_funct  out  6  D_instr[5:0].
- D_imm16  out  16  D_instr[15:0], to the immediate extender.
- D_index26  out  26  D_instr[25:0], jump target field.

Behaviour:
- Reset (reset=0, asynchronous, immediate):
  - D_pc=32'h0, D_instr=32'h0, D_exccode=5'd0.
  - D_bd=0, D_valid=0.
  - Field outputs are therefore all 0.
- Fetch exception detect, combinational on F inputs:
  - `adel = (F_pc[1:0]!=2'b00) | (F_pc<TEXT_LO) | (F_pc>TEXT_HI)`, unsigned compares.
  - Bounds are inclusive: F_pc=TEXT_HI is legal; F_pc=TEXT_HI+4 is AdEL.
- Update on rising clk when reset=1. Strict priority:
  1. req=1: D_instr=0, D_pc=EXC_PC, D_exccode=0, D_bd=0, D_valid=0. Applies even when en=0 (exception overrides stall).
  2. else en=0: all registers hold.
  3. else en=1, load:
     - D_pc=F_pc, D_bd=F_bd, D_valid=1.
     - D_instr = adel ? 32'h0 : F_instr (a faulting fetch is squashed to nop).
     - D_exccode = adel ? EXC_ADEL : 5'd0.
- Latency: one cycle F→D. Field outputs are pure slices of D_instr, zero extra latency.
- Cleared/reset state decodes as sll $0,$0,0 (nop). Downstream needs no special bubble handling beyond D_valid.
- Reset asserted mid-stall or mid-req: reset wins immediately. First post-reset edge follows the normal priority.
- PC values are never modified (no +4). Stored exactly as presented.

Decomposition:
- Shared package/header: TEXT_LO, TEXT_HI, EXC_PC, exception-code constants (EXC_INT=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12).
- The same constants are used by D/E, E/M and M/W stage registers and CP0.
- Optional sub-module: `fetch_addr_check` (F_pc → adel).
- The field slicer stays inline; it is too thin for its own module.

Test Plan:
- Reset low, then release with en=1, F_pc=32'h3000, F_instr=32'h3C01_1234 → after 1 edge: D_pc=3000, D_imm16=16'h1234, D_rt=1, D_valid=1, D_exccode=0.
- Stall: load 32'h3000/instr A; set en=0 for 3 edges while F changes to 32'h3004/instr B → D stays at 3000/A; en=1 → D=3004/B on next edge.
- Misaligned fetch: F_pc=32'h3002, F_instr=32'hFFFF_FFFF, en=1 → D_instr=0, D_exccode=4, D_pc=3002, D_valid=1.
- Range boundaries:
  - F_pc=32'h6FFC → exccode 0.
  - F_pc=32'h7000 → exccode 4.
  - F_pc=32'h2FFC → exccode 4.
- Exception clear during stall: D holds 3008 with D_bd=1; assert req=1 and en=0 → next edge D_pc=4180, D_instr=0, D_bd=0, D_valid=0.
- Async reset mid-operation: drop reset between edges while D holds valid data → outputs go to 0 before next clk edge; D_valid=0.

Source files
------------

// File: rtl/fd_pipe_reg_pkg.sv
// ----------------------------------------------------------------------------
// fd_pipe_reg_pkg
//   Constants shared by the pipeline stage registers and CP0: legal text
//   segment bounds, exception handler entry PC and CP0 exception codes.
//   Also holds the F/D stage state record and the fetch address check
//   helper so every stage register applies the same legality rule.
// ----------------------------------------------------------------------------
package fd_pipe_reg_pkg;

    // Instruction memory window, both bounds inclusive.
    localparam logic [31:0] TEXT_LO = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;

    // Handler entry PC loaded into a stage when CP0 takes an exception.
    localparam logic [31:0] EXC_PC = 32'h0000_4180;

    // CP0 Cause.ExcCode values.
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // State held between F and D.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exccode;
        logic        bd;
        logic        valid;
    } fd_state_t;

    // Fetch address error: misaligned word or outside [lo, hi] (unsigned).
    function automatic logic fetch_adel(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
        return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
    endfunction

endpackage

// File: rtl/fd_pipe_reg_fetch_addr_check.sv
// ----------------------------------------------------------------------------
// fd_pipe_reg_fetch_addr_check
//   Combinational fetch address legality check for the F stage.
//   Ports:
//     pc_i    in  32  PC of the instruction being fetched
//     adel_o  out  1  1 = address error on fetch (misaligned or out of text)
// ----------------------------------------------------------------------------
module fd_pipe_reg_fetch_addr_check #(
    parameter logic [31:0] TEXT_LO = fd_pipe_reg_pkg::TEXT_LO,
    parameter logic [31:0] TEXT_HI = fd_pipe_reg_pkg::TEXT_HI
) (
    input  logic [31:0] pc_i,
    output logic        adel_o
);
    import fd_pipe_reg_pkg::fetch_adel;

    always_comb begin
        adel_o = fetch_adel(pc_i, TEXT_LO, TEXT_HI);
    end

endmodule

// File: rtl/fd_pipe_reg.sv
// ----------------------------------------------------------------------------
// fd_pipe_reg
//   Fetch/Decode boundary register of the 5-stage MIPS pipeline. Captures the
//   fetched instruction, its PC, delay-slot flag and fetch exception, and
//   presents the held instruction's fields to the D-stage consumers.
//   Priority on each edge: exception clear > stall hold > load from F.
//   Ports:
//     clk        in   1  system clock, rising edge
//     reset      in   1  asynchronous active-low reset
//     en         in   1  1 = load from F, 0 = hold (stall)
//     req        in   1  exception/interrupt taken, clears the stage
//     F_pc       in  32  PC of the instruction in F
//     F_instr    in  32  instruction word from IM
//     F_bd       in   1  F instruction sits in a delay slot
//     D_pc       out 32  registered PC
//     D_instr    out 32  registered instruction (0 = nop)
//     D_exccode  out  5  registered fetch exception code (0 = none)
//     D_bd       out  1  registered delay-slot flag
//     D_valid    out  1  D holds a real fetched instruction
//     D_opcode .. D_index26  field slices of D_instr
// ----------------------------------------------------------------------------
module fd_pipe_reg #(
    parameter logic [31:0] TEXT_LO  = fd_pipe_reg_pkg::TEXT_LO,
    parameter logic [31:0] TEXT_HI  = fd_pipe_reg_pkg::TEXT_HI,
    parameter logic [31:0] EXC_PC   = fd_pipe_reg_pkg::EXC_PC,
    parameter logic [4:0]  EXC_ADEL = fd_pipe_reg_pkg::EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        req,
    input  logic [31:0] F_pc,
    input  logic [31:0] F_instr,
    input  logic        F_bd,
    output logic [31:0] D_pc,
    output logic [31:0] D_instr,
    output logic [4:0]  D_exccode,
    output logic        D_bd,
    output logic        D_valid,
    output logic [5:0]  D_opcode,
    output logic [4:0]  D_rs,
    output logic [4:0]  D_rt,
    output logic [4:0]  D_rd,
    output logic [4:0]  D_shamt,
    output logic [5:0]  D_funct,
    output logic [15:0] D_imm16,
    output logic [25:0] D_index26
);
    import fd_pipe_reg_pkg::fd_state_t;

    fd_state_t fd_d;
    fd_state_t fd_q;
    logic      adel;

    fd_pipe_reg_fetch_addr_check #(
        .TEXT_LO (TEXT_LO),
        .TEXT_HI (TEXT_HI)
    ) u_fetch_addr_check (
        .pc_i   (F_pc),
        .adel_o (adel)
    );

    always_comb begin
        fd_d = fd_q;
        if (req) begin
            // Exception overrides a stall; the cleared stage decodes as a nop
            // bubble parked at the handler entry.
            fd_d.pc      = EXC_PC;
            fd_d.instr   = 32'h0;
            fd_d.exccode = 5'd0;
            fd_d.bd      = 1'b0;
            fd_d.valid   = 1'b0;
        end else if (en) begin
            // A faulting fetch still occupies the slot (valid) so CP0 sees
            // the exception, but its word is squashed to a nop.
            fd_d.pc      = F_pc;
            fd_d.instr   = adel ? 32'h0 : F_instr;
            fd_d.exccode = adel ? EXC_ADEL : 5'd0;
            fd_d.bd      = F_bd;
            fd_d.valid   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fd_q <= '0;
        end else begin
            fd_q <= fd_d;
        end
    end

    assign D_pc      = fd_q.pc;
    assign D_instr   = fd_q.instr;
    assign D_exccode = fd_q.exccode;
    assign D_bd      = fd_q.bd;
    assign D_valid   = fd_q.valid;

    // Field slicer: pure wiring off the held instruction.
    assign D_opcode  = fd_q.instr[31:26];
    assign D_rs      = fd_q.instr[25:21];
    assign D_rt      = fd_q.instr[20:16];
    assign D_rd      = fd_q.instr[15:11];
    assign D_shamt   = fd_q.instr[10:6];
    assign D_funct   = fd_q.instr[5:0];
    assign D_imm16   = fd_q.instr[15:0];
    assign D_index26 = fd_q.instr[25:0];

endmodule

// File: tb/tb_fd_pipe_reg.sv
// ----------------------------------------------------------------------------
// tb_fd_pipe_reg
//   Self-checking bench for fd_pipe_reg: directed scenarios followed by
//   randomized traffic, compared against a behavioural model of the stage.
// ----------------------------------------------------------------------------
module tb_fd_pipe_reg;

    logic        clk;
    logic        reset;
    logic        en;
    logic        req;
    logic [31:0] F_pc;
    logic [31:0] F_instr;
    logic        F_bd;
    logic [31:0] D_pc;
    logic [31:0] D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd;
    logic        D_valid;
    logic [5:0]  D_opcode;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [4:0]  D_rd;
    logic [4:0]  D_shamt;
    logic [5:0]  D_funct;
    logic [15:0] D_imm16;
    logic [25:0] D_index26;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [4:0]  m_exc;
    logic        m_bd;
    logic        m_valid;

    fd_pipe_reg u_dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req       (req),
        .F_pc      (F_pc),
        .F_instr   (F_instr),
        .F_bd      (F_bd),
        .D_pc      (D_pc),
        .D_instr   (D_instr),
        .D_exccode (D_exccode),
        .D_bd      (D_bd),
        .D_valid   (D_valid),
        .D_opcode  (D_opcode),
        .D_rs      (D_rs),
        .D_rt      (D_rt),
        .D_rd      (D_rd),
        .D_shamt   (D_shamt),
        .D_funct   (D_funct),
        .D_imm16   (D_imm16),
        .D_index26 (D_index26)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Fetch legality from the memory map: word aligned, 0x3000..0x6FFC.
    function automatic logic model_adel(input logic [31:0] pc);
        longint unsigned a;
        a = longint'(pc);
        return (a % 4 != 0) || (a < 64'h3000) || (a > 64'h6FFC);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
    endtask

    task automatic model_clock();
        if (req) begin
            m_pc = 32'h4180; m_instr = 0; m_exc = 0; m_bd = 0; m_valid = 0;
        end else if (en) begin
            m_pc    = F_pc;
            m_bd    = F_bd;
            m_valid = 1'b1;
            m_instr = model_adel(F_pc) ? 32'h0 : F_instr;
            m_exc   = model_adel(F_pc) ? 5'd4 : 5'd0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [31:0] w;
        w = m_instr;
        check_val({tag, ".pc"},      D_pc,      m_pc);
        check_val({tag, ".instr"},   D_instr,   m_instr);
        check_val({tag, ".exccode"}, {27'h0, D_exccode}, {27'h0, m_exc});
        check_val({tag, ".bd"},      {31'h0, D_bd},      {31'h0, m_bd});
        check_val({tag, ".valid"},   {31'h0, D_valid},   {31'h0, m_valid});
        check_val({tag, ".opcode"},  {26'h0, D_opcode},  {26'h0, w[31:26]});
        check_val({tag, ".rs"},      {27'h0, D_rs},      {27'h0, w[25:21]});
        check_val({tag, ".rt"},      {27'h0, D_rt},      {27'h0, w[20:16]});
        check_val({tag, ".rd"},      {27'h0, D_rd},      {27'h0, w[15:11]});
        check_val({tag, ".shamt"},   {27'h0, D_shamt},   {27'h0, w[10:6]});
        check_val({tag, ".funct"},   {26'h0, D_funct},   {26'h0, w[5:0]});
        check_val({tag, ".imm16"},   {16'h0, D_imm16},   {16'h0, w[15:0]});
        check_val({tag, ".index26"}, {6'h0, D_index26},  {6'h0, w[25:0]});
    endtask

    // One clock edge: advance the model, then sample just after the edge.
    task automatic step(input string tag);
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic e, input logic r, input logic [31:0] pc,
                         input logic [31:0] instr, input logic bd);
        en = e; req = r; F_pc = pc; F_instr = instr; F_bd = bd;
    endtask

    // Pulse reset between edges; called 1 time unit after a posedge.
    task automatic mid_cycle_reset(input string tag);
        #1 reset = 1'b0;
        model_reset();
        #1 check_all(tag);
        #1 reset = 1'b1;
    endtask

    function automatic logic [31:0] rand_pc();
        case ($urandom_range(0, 5))
            0:       return 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            1:       return 32'h6FFC + ($urandom_range(0, 2) << 2) - 32'h4;
            2:       return 32'h2FFC + ($urandom_range(0, 2) << 2);
            3:       return (32'h3000 + ($urandom_range(0, 32'hFFF) << 2))
                            | 32'($urandom_range(1, 3));
            default: return $urandom();
        endcase
    endfunction

    initial begin
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        model_reset();
        #1 check_all("reset");
        @(negedge clk);
        @(negedge clk);
        check_all("reset_hold");
        reset = 1'b1;

        // First fetch after reset: lui $1, 0x1234.
        drive(1'b1, 1'b0, 32'h3000, 32'h3C01_1234, 1'b0);
        step("first");
        check_val("first.imm16_const", {16'h0, D_imm16}, 32'h1234);
        check_val("first.rt_const", {27'h0, D_rt}, 32'd1);

        // Stall hold: F moves on while en=0.
        drive(1'b1, 1'b0, 32'h3000, 32'h2402_00AA, 1'b0);
        step("stall_load");
        drive(1'b0, 1'b0, 32'h3004, 32'h2403_00BB, 1'b0);
        for (int i = 0; i < 3; i++) step("stall_hold");
        check_val("stall.pc_const", D_pc, 32'h3000);
        drive(1'b1, 1'b0, 32'h3004, 32'h2403_00BB, 1'b0);
        step("stall_release");
        check_val("stall_release.pc_const", D_pc, 32'h3004);

        // Misaligned fetch squashed to nop with AdEL.
        drive(1'b1, 1'b0, 32'h3002, 32'hFFFF_FFFF, 1'b0);
        step("misaligned");
        check_val("misaligned.exc_const", {27'h0, D_exccode}, 32'd4);
        check_val("misaligned.instr_const", D_instr, 32'h0);

        // Range boundaries.
        drive(1'b1, 1'b0, 32'h6FFC, 32'h1234_5678, 1'b1);
        step("text_hi");
        check_val("text_hi.exc_const", {27'h0, D_exccode}, 32'd0);
        drive(1'b1, 1'b0, 32'h7000, 32'h1234_5678, 1'b0);
        step("text_hi_plus4");
        check_val("text_hi_plus4.exc_const", {27'h0, D_exccode}, 32'd4);
        drive(1'b1, 1'b0, 32'h2FFC, 32'h1234_5678, 1'b0);
        step("text_lo_minus4");
        check_val("text_lo_minus4.exc_const", {27'h0, D_exccode}, 32'd4);
        drive(1'b1, 1'b0, 32'h3000, 32'h8765_4321, 1'b0);
        step("text_lo");

        // Exception clear while stalled.
        drive(1'b1, 1'b0, 32'h3008, 32'h0000_0020, 1'b1);
        step("bd_load");
        drive(1'b0, 1'b1, 32'h300C, 32'h0000_0021, 1'b0);
        step("req_stall");
        check_val("req_stall.pc_const", D_pc, 32'h4180);
        check_val("req_stall.valid_const", {31'h0, D_valid}, 32'd0);

        // Asynchronous reset while D holds valid data.
        drive(1'b1, 1'b0, 32'h3010, 32'hABCD_EF01, 1'b1);
        step("pre_async");
        mid_cycle_reset("async_reset");
        check_val("async_reset.valid_const", {31'h0, D_valid}, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  rand_pc(), $urandom(), 1'($urandom_range(0, 1)));
            step("rand");
            if ($urandom_range(0, 39) == 0) mid_cycle_reset("rand_async");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
